// File: rtl/injector_pulse_timer_pkg.sv
// ============================================================================
// injector_pulse_timer_pkg : shared state encoding and default timing constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package injector_pulse_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PULSE   = 2'b01,
    ST_DONE    = 2'b10,
    ST_RELEASE = 2'b11
  } state_e;

  // Shared with the injection-time calculator
  localparam int DEF_TICK_DIV = 50;
  localparam int DEF_MAX_US   = 20000;

endpackage

`default_nettype wire

// File: rtl/injector_pulse_timer_us_tick_gen.sv
// ============================================================================
// us_tick_gen : free-running prescaler with synchronous clear; one-cycle tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module us_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/injector_pulse_timer.sv
// ============================================================================
// injector_pulse_timer : turns the inject request into a timed injector pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module injector_pulse_timer
  import injector_pulse_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TIME_W   = 16,
  parameter int MAX_US   = DEF_MAX_US
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              on,
  input  logic              inject,
  input  logic [TIME_W-1:0] inj_time_us,
  input  logic              inj_time_load,
  output logic              injector_out,
  output logic              done,
  output logic              busy,
  output logic              clamped,
  output logic [7:0]        pulse_count
);

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_US);

  state_e            state_q, state_d;
  logic              inject_dly_q;
  logic [TIME_W-1:0] shadow_q, shadow_d;
  logic [TIME_W-1:0] counter_q, counter_d;
  logic              clamped_q, clamped_d;
  logic [7:0]        pulse_count_q, pulse_count_d;
  logic              injector_out_q, injector_out_d;
  logic              done_q, done_d;
  logic              rise;
  logic              tick;

  us_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != ST_PULSE),
    .tick    (tick)
  );

  always_comb begin
    rise          = inject && !inject_dly_q;
    state_d       = state_q;
    shadow_d      = shadow_q;
    clamped_d     = clamped_q;
    counter_d     = counter_q;
    pulse_count_d = pulse_count_q;

    // The running pulse keeps using counter_q; a new load only reaches the next pulse
    if (inj_time_load) begin
      if (inj_time_us > MAX_T) begin
        shadow_d  = MAX_T;
        clamped_d = 1'b1;
      end else begin
        shadow_d  = inj_time_us;
        clamped_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rise && on) begin
          if (shadow_q != '0) begin
            counter_d = shadow_q;
            state_d   = ST_PULSE;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_PULSE: begin
        if (tick) begin
          counter_d = counter_q - TIME_W'(1);
          if (counter_q == TIME_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        pulse_count_d = pulse_count_q + 8'd1;
        state_d       = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!inject) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!on) begin
      state_d = ST_IDLE;
    end

    // Outputs registered from next state so they align exactly with the state
    injector_out_d = (state_d == ST_PULSE);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      inject_dly_q   <= 1'b0;
      shadow_q       <= '0;
      counter_q      <= '0;
      clamped_q      <= 1'b0;
      pulse_count_q  <= 8'd0;
      injector_out_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      inject_dly_q   <= inject;
      shadow_q       <= shadow_d;
      counter_q      <= counter_d;
      clamped_q      <= clamped_d;
      pulse_count_q  <= pulse_count_d;
      injector_out_q <= injector_out_d;
      done_q         <= done_d;
    end
  end

  assign injector_out = injector_out_q;
  assign done         = done_q;
  assign busy         = (state_q != ST_IDLE);
  assign clamped      = clamped_q;
  assign pulse_count  = pulse_count_q;

endmodule

`default_nettype wire
